spr_rom_fetch: RTL and testbench

SPR_ROM_FETCH -- requirements
Module: spr_rom_fetch

---
 rtl/spr_rom_fetch_pkg.sv | 23 ++
 rtl/spr_rom_fetch_swizzle.sv | 11 +
 rtl/spr_rom_fetch.sv | 85 ++++++++
 tb/tb_spr_rom_fetch.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spr_rom_fetch_pkg.sv
// spr_rom_fetch_pkg: shared state type, address permutation table and planar swizzle
package spr_rom_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;
  localparam int MAX_DW = 256;
  function automatic logic [8:0] dec_perm(input logic [2:0] mode, input logic [9:0] c);
    case (mode)
      3'd0: return {c[9:4], c[2:0]};
      3'd1: return {c[9:7], c[5], c[6], c[4], c[2:0]};
      3'd2, 3'd3: return {c[9:6], c[4], c[2:0], c[5]};
      3'd4: return {c[9], c[7], c[8], c[6], c[4], c[2:0], c[5]};
      3'd5, 3'd6: return {c[9:8], c[6], c[4], c[2:0], c[7], c[5]};
      default: return {c[8], c[6], c[4], c[2:0], c[9], c[7], c[5]};
    endcase
  endfunction
  function automatic logic [MAX_DW-1:0] planar_swizzle(input logic [MAX_DW-1:0] d, input int planes, input int pix);
    logic [MAX_DW-1:0] q;
    q = '0;
    for (int p = 0; p < planes; p++)
      for (int i = 0; i < pix; i++)
        q[p*pix+i] = d[i*planes+p];
    return q;
  endfunction
endpackage

// File: rtl/spr_rom_fetch_swizzle.sv
// spr_planar_swizzle: chunky-to-planar bit transpose of one ROM word
module spr_planar_swizzle import spr_rom_fetch_pkg::*; #(
  parameter int PLANES = 4,
  parameter int PIX = 8
) (
  input  logic [PLANES*PIX-1:0] chunky,
  output logic [PLANES*PIX-1:0] planar
);
  localparam int DW = PLANES*PIX;
  assign planar = DW'(planar_swizzle(MAX_DW'(chunky), PLANES, PIX));
endmodule

// File: rtl/spr_rom_fetch.sv
// spr_rom_fetch: sprite ROM word fetch with address permutation, one-entry pending buffer and ack timeout
module spr_rom_fetch import spr_rom_fetch_pkg::*; #(
  parameter int PLANES = 4,
  parameter int PIX = 8,
  parameter int CAW = 18,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk_main,
  input  logic                  reset,
  input  logic                  fetch_stb,
  input  logic [CAW-1:0]        ca,
  input  logic                  bank,
  input  logic [2:0]            mode,
  output logic [CAW:0]          rom_addr,
  output logic                  rom_req,
  input  logic                  rom_ack,
  input  logic [PLANES*PIX-1:0] rom_data,
  output logic [PLANES*PIX-1:0] pix_planar,
  output logic                  pix_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  tmo_err
);
  localparam int DW = PLANES*PIX;
  localparam int CW = $clog2(TIMEOUT+1);
  state_t state;
  logic [CW-1:0] cnt;
  logic pend, pend_bank, src_bank;
  logic [CAW-1:0] pend_ca, src_ca;
  logic [2:0] pend_mode, src_mode;
  logic [DW-1:0] planar_w;
  logic [CAW:0] next_addr;
  // a held request is older than a simultaneous strobe, so it launches first
  assign src_bank = pend ? pend_bank : bank;
  assign src_ca = pend ? pend_ca : ca;
  assign src_mode = pend ? pend_mode : mode;
  assign next_addr = {src_bank, src_ca[CAW-1:10], dec_perm(src_mode, src_ca[9:0]), src_ca[3]};
  spr_planar_swizzle #(.PLANES(PLANES), .PIX(PIX)) u_swz (.chunky(rom_data), .planar(planar_w));
  always_ff @(posedge clk_main) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      pend_bank <= 1'b0;
      pend_ca <= '0;
      pend_mode <= '0;
      rom_addr <= '0;
      rom_req <= 1'b0;
      pix_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      tmo_err <= 1'b0;
      pix_planar <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (fetch_stb && (state != IDLE || pend)) begin
        pend <= 1'b1;
        pend_bank <= bank;
        pend_ca <= ca;
        pend_mode <= mode;
        overrun <= overrun | (pend && state != IDLE);
      end else if (state == IDLE && pend) pend <= 1'b0;
      case (state)
        IDLE: if (fetch_stb || pend) begin
          state <= REQ;
          rom_req <= 1'b1;
          busy <= 1'b1;
          rom_addr <= next_addr;
          cnt <= '0;
        end
        REQ: if (rom_ack || cnt == CW'(TIMEOUT)) begin
          state <= OUT;
          rom_req <= 1'b0;
          pix_valid <= 1'b1;
          if (rom_ack) pix_planar <= planar_w;
          else tmo_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spr_rom_fetch.sv
// tb_spr_rom_fetch: randomized fetches checked against a transaction-level reference model
module tb_spr_rom_fetch;
  localparam int PLANES = 4, PIX = 8, CAW = 18, TIMEOUT = 63;
  localparam int DW = PLANES*PIX;
  logic clk = 0, reset = 1, fetch_stb = 0, bank = 0, rom_ack = 0;
  logic [CAW-1:0] ca = '0;
  logic [2:0] mode = '0;
  logic [DW-1:0] rom_data = '0, pix_planar, last_good;
  logic [CAW:0] rom_addr;
  logic rom_req, pix_valid, busy, overrun, tmo_err;
  int n_tests = 0, n_fail = 0;
  int perm_tab [8][9] = '{'{9,8,7,6,5,4,2,1,0}, '{9,8,7,5,6,4,2,1,0}, '{9,8,7,6,4,2,1,0,5},
                          '{9,8,7,6,4,2,1,0,5}, '{9,7,8,6,4,2,1,0,5}, '{9,8,6,4,2,1,0,7,5},
                          '{9,8,6,4,2,1,0,7,5}, '{8,6,4,2,1,0,9,7,5}};

  spr_rom_fetch #(.PLANES(PLANES), .PIX(PIX), .CAW(CAW), .TIMEOUT(TIMEOUT)) dut (
    .clk_main(clk), .reset(reset), .fetch_stb(fetch_stb), .ca(ca), .bank(bank), .mode(mode),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .pix_planar(pix_planar), .pix_valid(pix_valid), .busy(busy), .overrun(overrun), .tmo_err(tmo_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CAW:0] ref_addr(input logic b, input logic [CAW-1:0] c, input logic [2:0] m);
    longint dec = 0;
    for (int j = 0; j < 9; j++) dec = dec * 2 + longint'(c[perm_tab[m][j]]);
    return (CAW+1)'((longint'(b) << CAW) | (longint'(c) & ~longint'(1023)) | (dec << 1) | longint'(c[3]));
  endfunction

  function automatic logic [DW-1:0] ref_swz(input logic [DW-1:0] w);
    logic [DW-1:0] r = '0;
    for (int n = 0; n < DW; n++) r[(n % PLANES) * PIX + n / PLANES] = w[n];
    return r;
  endfunction

  // One fetch; the ack arrives d cycles into REQ, or never when give_ack is clear
  task automatic run_fetch(input string tag, input logic b, input logic [CAW-1:0] c, input logic [2:0] m,
                           input int d, input logic [DW-1:0] w, input bit give_ack);
    logic [CAW:0] exp_addr;
    int lat = -1;
    exp_addr = ref_addr(b, c, m);
    @(posedge clk); #1;
    fetch_stb = 1; bank = b; ca = c; mode = m;
    for (int k = 1; k <= 80 && lat < 0; k++) begin
      @(posedge clk); #1;
      fetch_stb = 0;
      rom_ack = give_ack && (k - 1 == d);
      rom_data = rom_ack ? w : DW'($urandom);
      if (k == 1) begin
        check({tag, "_req"}, rom_req, 1);
        check({tag, "_addr"}, rom_addr, exp_addr);
      end
      if (k == d + 1 && give_ack) check({tag, "_addr_hold"}, rom_addr, exp_addr);
      if (pix_valid) lat = k;
    end
    rom_ack = 0;
    check({tag, "_lat"}, lat, give_ack ? 2 + d : 2 + TIMEOUT);
    if (give_ack) last_good = ref_swz(w);
    check({tag, "_pix"}, pix_planar, last_good);
    check({tag, "_req_low"}, rom_req, 0);
    @(posedge clk); #1;
    check({tag, "_valid_1cyc"}, pix_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_pending();
    logic [CAW-1:0] cs[3];
    logic bs[3];
    logic [2:0] ms[3];
    logic [DW-1:0] w1, w2;
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cs[i] = CAW'($urandom); bs[i] = 1'($urandom); ms[i] = 3'($urandom);
    end
    w1 = DW'($urandom); w2 = DW'($urandom);
    @(posedge clk); #1;
    fetch_stb = 1; bank = bs[0]; ca = cs[0]; mode = ms[0];
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      fetch_stb = (k <= 2);
      if (k <= 2) begin bank = bs[k]; ca = cs[k]; mode = ms[k]; end
      rom_ack = rom_req && (k == 4 || k == 8);
      rom_data = (k == 4) ? w1 : w2;
      if (k == 1) check("pend_addr0", rom_addr, ref_addr(bs[0], cs[0], ms[0]));
      if (k == 8) check("pend_addr2", rom_addr, ref_addr(bs[2], cs[2], ms[2]));
      if (pix_valid) begin
        pulses++;
        check(pulses == 1 ? "pend_pix1" : "pend_pix2", pix_planar, pulses == 1 ? ref_swz(w1) : ref_swz(w2));
      end
    end
    rom_ack = 0;
    check("pend_pulses", pulses, 2);
    check("overrun_set", overrun, 1);
    last_good = ref_swz(w2);
  endtask

  task automatic run_reset_mid_req();
    int pulses = 0;
    @(posedge clk); #1;
    fetch_stb = 1; bank = 1; ca = CAW'($urandom); mode = 3'($urandom);
    @(posedge clk); #1;
    fetch_stb = 0;
    check("rst_pre_req", rom_req, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; rom_ack = 1; rom_data = DW'($urandom);
    check("rst_req_drop", rom_req, 0);
    if (pix_valid) pulses++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rom_ack = 0;
      if (pix_valid) pulses++;
    end
    last_good = '0;
    check("rst_no_valid", pulses, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_pix", pix_planar, 0);
    check("rst_busy", busy, 0);
    check("rst_req", rom_req, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tmo", tmo_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    last_good = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_req", rom_req, 0);
    check("reset_valid", pix_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_tmo", tmo_err, 0);
    check("reset_addr", rom_addr, 0);
    check("reset_pix", pix_planar, 0);
    run_fetch("allones", 1, 18'h3FFFF, 0, 3, DW'($urandom), 1);
    run_fetch("m7_bit9", 0, 18'h00200, 7, 1, DW'($urandom), 1);
    run_fetch("m4_bit9", 0, 18'h00200, 4, 2, DW'($urandom), 1);
    run_fetch("data_b0", 0, 18'h00000, 0, 0, 32'h00000001, 1);
    run_fetch("data_b1", 0, 18'h00008, 1, 0, 32'h00000002, 1);
    run_fetch("data_b31", 1, 18'h00400, 2, 0, 32'h80000000, 1);
    for (int i = 0; i < 24; i++)
      run_fetch("rand", 1'($urandom), CAW'($urandom), 3'($urandom), int'($urandom_range(0, 6)), DW'($urandom), 1);
    check("no_overrun_yet", overrun, 0);
    run_fetch("ack_at_tmo", 0, CAW'($urandom), 3'($urandom), TIMEOUT, DW'($urandom), 1);
    check("ack_wins_tmo", tmo_err, 0);
    run_fetch("timeout", 1, CAW'($urandom), 3'($urandom), 0, '0, 0);
    check("tmo_set", tmo_err, 1);
    run_pending();
    check("tmo_sticky", tmo_err, 1);
    run_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
